// File: rtl/traffic_pkg.sv
// Shared definitions for the four-approach traffic phase scheduler:
// phase encodings, approach indices, counter width and round-robin helpers.
package traffic_pkg;

    localparam int NUM_APPR = 4;
    localparam int CNT_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GREEN   = 2'd1,
        ST_YELLOW  = 2'd2,
        ST_ALL_RED = 2'd3
    } phase_e;

    typedef enum logic [1:0] {
        APPR_N = 2'd0,
        APPR_E = 2'd1,
        APPR_S = 2'd2,
        APPR_W = 2'd3
    } appr_e;

    function automatic logic [NUM_APPR-1:0] appr_onehot(input logic [1:0] idx);
        appr_onehot = 4'b0001 << idx;
    endfunction

    // Walk from last+4 (== last) down to last+1 so the nearest requester after
    // the previous winner is the final assignment and therefore wins.
    function automatic logic [1:0] rr_pick(input logic [NUM_APPR-1:0] req,
                                           input logic [1:0] last);
        logic [1:0] cand;
        rr_pick = last;
        for (int k = NUM_APPR; k >= 1; k--) begin
            cand = last + 2'(k);
            if (req[cand]) begin
                rr_pick = cand;
            end
        end
    endfunction

endpackage

// File: rtl/traffic_phase_scheduler_timer.sv
// Elapsed-cycle counter for the current phase: restart loads 1, otherwise
// counts up while enabled and saturates at the counter maximum.
module phase_timer
    import traffic_pkg::*;
(
    input  logic             clk,
    input  logic             res_n,
    input  logic             restart_i,
    input  logic             cnt_en_i,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (restart_i) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_en_i && (cnt_q != CNT_SAT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Four-approach round-robin traffic phase scheduler with minimum/maximum green,
// fixed yellow and all-red clearance; lamps are decoded from registered state only.
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int unsigned GREEN_MIN = 4,
    parameter int unsigned GREEN_MAX = 8,
    parameter int unsigned YELLOW_T  = 2,
    parameter int unsigned ALLRED_T  = 1
) (
    input  logic                clk,
    input  logic                res_n,
    input  logic                en,
    input  logic [NUM_APPR-1:0] req,
    output logic [NUM_APPR-1:0] green,
    output logic [NUM_APPR-1:0] yellow,
    output logic [1:0]          phase,
    output logic                busy
);

    localparam logic [CNT_W-1:0] GMIN = CNT_W'(GREEN_MIN);
    localparam logic [CNT_W-1:0] GMAX = CNT_W'(GREEN_MAX);
    localparam logic [CNT_W-1:0] YT   = CNT_W'(YELLOW_T);
    localparam logic [CNT_W-1:0] AT   = CNT_W'(ALLRED_T);

    phase_e           state_q, state_d;
    logic [1:0]       cur_q, cur_d;
    logic [1:0]       last_q, last_d;
    logic [CNT_W-1:0] cnt;
    logic             others;
    logic             grant_ok;
    logic [1:0]       winner;
    logic             restart;

    phase_timer u_timer (
        .clk       (clk),
        .res_n     (res_n),
        .restart_i (restart),
        .cnt_en_i  (state_q != ST_IDLE),
        .cnt_o     (cnt)
    );

    always_comb begin
        others   = en && (|(req & ~appr_onehot(cur_q)));
        grant_ok = en && (|req);
        winner   = rr_pick(req, last_q);
        state_d  = state_q;
        cur_d    = cur_q;
        last_d   = last_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_ok) begin
                    state_d = ST_GREEN;
                    cur_d   = winner;
                    last_d  = winner;
                end
            end
            ST_GREEN: begin
                // Minimum green always honoured; then leave on release, on
                // enable drop, or on max-green pre-emption by a waiting approach.
                if ((cnt >= GMIN) &&
                    (!req[cur_q] || !en || (others && (cnt >= GMAX)))) begin
                    state_d = ST_YELLOW;
                end
            end
            ST_YELLOW: begin
                if (cnt >= YT) begin
                    state_d = ST_ALL_RED;
                end
            end
            ST_ALL_RED: begin
                if (cnt >= AT) begin
                    if (grant_ok) begin
                        state_d = ST_GREEN;
                        cur_d   = winner;
                        last_d  = winner;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        restart = (state_d != state_q);
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q <= ST_IDLE;
            cur_q   <= APPR_N;
            last_q  <= APPR_W;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            last_q  <= last_d;
        end
    end

    for (genvar gi = 0; gi < NUM_APPR; gi++) begin : g_lamp
        assign green[gi]  = (state_q == ST_GREEN)  && (cur_q == 2'(gi));
        assign yellow[gi] = (state_q == ST_YELLOW) && (cur_q == 2'(gi));
    end

    assign phase = state_q;
    assign busy  = (state_q != ST_IDLE);

endmodule

// File: doc/traffic_phase_scheduler.md
TRAFFIC_PHASE_SCHEDULER -- requirements
Module: traffic_phase_scheduler

Interface
REQ-001 Parameter GREEN_MIN, default 4, minimum green cycles per grant (1..15).
REQ-002 Parameter GREEN_MAX, default 8, green cycles after which a held grant is pre-empted if others wait (GREEN_MIN..15).
REQ-003 Parameter YELLOW_T, default 2, yellow cycles (1..15).
REQ-004 Parameter ALLRED_T, default 1, all-red clearance cycles (1..15).
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 res_n  input  1  reset, asynchronous assert, active-low.
REQ-007 en  input  1  arbitration enable; 0 = no new grants.
REQ-008 req  input  4  per-approach vehicle request, index 0..3 = N,E,S,W, level-sensitive.
REQ-009 green  output  4  one-hot or zero; green lamp per approach.
REQ-010 yellow  output  4  one-hot or zero; yellow lamp per approach.
REQ-011 phase  output  2  current FSM state encoding.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 FSM states SHALL be IDLE=0, GREEN=1, YELLOW=2, ALL_RED=3; outputs Moore-decoded from registered state, current grant index and elapsed counter.
REQ-014 Red lamp for approach i SHALL be implied: ~(green[i]|yellow[i]); never is more than one bit of green|yellow set.
REQ-015 Arbitration SHALL be round-robin: search starts at (last+1) mod 4, first set req bit wins; last updates to winner on grant.
REQ-016 IDLE: if en && |req at an edge, SHALL enter GREEN for the winner next cycle; otherwise stays IDLE.
REQ-017 GREEN: 4-bit elapsed counter SHALL read 1 on the first GREEN cycle and increment each cycle, saturating at 15.
REQ-018 "others" SHALL mean |(req & ~onehot(cur)) && en.
REQ-019 GREEN exit to YELLOW SHALL occur at the edge where cnt>=GREEN_MIN and (req[cur]==0 or (others and cnt>=GREEN_MAX)), or cnt>=GREEN_MIN and en==0.
REQ-020 With req[cur] held, en=1 and no others, GREEN SHALL hold indefinitely (rest-in-green).
REQ-021 YELLOW SHALL last exactly YELLOW_T cycles on the same approach, then ALL_RED for exactly ALLRED_T cycles with green=yellow=0.
REQ-022 At ALL_RED end: if en && |req, SHALL go directly to GREEN for the round-robin winner (may re-grant cur if it is the only requester); else IDLE.
REQ-023 Requests arriving in YELLOW/ALL_RED SHALL not shorten or extend those phases.
REQ-024 Counter SHALL reload to 1 on every state entry; no phase shortened by simultaneous req/en changes.

Reset
REQ-025 res_n=0 SHALL immediately force state IDLE, green=0, yellow=0, phase=0, busy=0, cnt=0, last=3 (so approach 0 wins first), regardless of clock.
REQ-026 Reset mid-phase (including YELLOW) SHALL abandon the phase; no yellow completion.
REQ-027 After res_n rises, first grant SHALL occur no earlier than the first rising edge with res_n=1.

Structure
REQ-028 State encodings, approach indices and counter width SHALL live in shared package traffic_pkg.
REQ-029 Elapsed/loaded cycle counting SHALL be one sub-module phase_timer (clear, count, saturate at 15).
REQ-030 Target 120-400 lines RTL; no combinational path from req to green/yellow.

Verification
REQ-031 Reset, en=1, req=0001 held -> green=0001 one cycle after first sampling edge, stays 0001 for 40+ cycles, yellow=0.
REQ-032 req=0001 held, then req=0011 -> green=0001 exactly 8 cycles total, yellow=0001 2 cycles, all-zero 1 cycle, then green=0010.
REQ-033 req=1111 from reset -> green sequence 0001,0010,0100,1000,0001, each 8 green, 2 yellow, 1 all-red.
REQ-034 req=0001 dropped at green cycle 2 -> green 4 cycles, yellow 2, all-red 1, then IDLE (busy=0).
REQ-035 en=0 at green cycle 6 of 0001 with req=0011 -> immediate YELLOW next edge, then ALL_RED, then IDLE; no grant until en=1.
REQ-036 res_n low during YELLOW -> green=yellow=0, phase=0 asynchronously; after release req=0100 -> green=0100.
